// File: rtl/fifo_axis_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_axis_packetizer_pkg
// Description : Shared defaults and FSM state encoding for the FIFO-to-AXIS
//               packetizer and its output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_axis_packetizer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_axis_packetizer_skid.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buf
// Description : Two-entry registered output buffer. The head entry drives the
//               stream directly, so data/last stay stable while stalled.
//               The writer must never push into a full buffer unless the same
//               cycle pops.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buf
    import fifo_axis_packetizer_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst,      // synchronous, active-low
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

    // Head/tail shift register: head only changes on a pop or when empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_axis_packetizer
// Description : Reads words from a standard (one-cycle latency) FIFO and
//               emits them as fixed-length AXI-Stream packets with tlast on
//               the final beat. Counts completed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_packetizer
    import fifo_axis_packetizer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst,          // synchronous, active-low
    input  logic                enable,
    input  logic [LEN_W-1:0]    pkt_len,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [DATA_W-1:0]   fifo_dout,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic [31:0]         pkt_count,
    output logic                busy
);

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic               r_rd_pend;     // read issued last cycle, data on fifo_dout now
    logic               r_pend_last;   // that read was the packet's final word
    logic [31:0]        r_pkt_count;

    logic [1:0]         w_buf_count;
    logic               w_buf_valid;
    logic [DATA_W:0]    w_buf_data;
    logic               w_handshake;
    logic [2:0]         w_occ;
    logic               w_issue_last;
    logic               w_rd_en;

    assign w_handshake  = w_buf_valid && m_axis_tready;
    assign w_issue_last = (r_issued == (r_len - c_len_one));

    // Occupancy counts the beat leaving this cycle as already freed, so the
    // two-entry buffer sustains one read per cycle without ever overflowing.
    assign w_occ = {1'b0, w_buf_count} + {2'b00, r_rd_pend} - {2'b00, w_handshake};

    // Read strobe is combinational so it can respect the live fifo_empty flag;
    // gating with rst keeps reads from being issued during a reset cycle.
    assign w_rd_en = rst && (r_state == ST_STREAM) && !fifo_empty &&
                     (r_issued != r_len) && (w_occ < 3'd2);

    assign fifo_rd_en    = w_rd_en;
    assign m_axis_tvalid = w_buf_valid;
    assign m_axis_tdata  = w_buf_data[DATA_W-1:0];
    assign m_axis_tlast  = w_buf_data[DATA_W];
    assign m_axis_tkeep  = '1;
    assign pkt_count     = r_pkt_count;
    assign busy          = (r_state != ST_IDLE);

    // Packet FSM, read bookkeeping and completed-packet counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_rd_pend   <= 1'b0;
            r_pend_last <= 1'b0;
            r_pkt_count <= 32'd0;
        end else begin
            r_rd_pend   <= w_rd_en;
            r_pend_last <= w_rd_en && w_issue_last;
            if (w_handshake && m_axis_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable && (pkt_len != '0)) begin
                        r_state  <= ST_STREAM;
                        r_len    <= pkt_len;
                        r_issued <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + c_len_one;
                        if (w_issue_last) r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_handshake && m_axis_tlast) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_rd_pend),
        .i_data  ({r_pend_last, fifo_dout}),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .i_ready (m_axis_tready),
        .o_count (w_buf_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_axis_packetizer
// Description : Directed self-checking bench for fifo_axis_packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_axis_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pkt_len;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic [31:0] pkt_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // upstream FIFO model
    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty = 1'b0;

    // ready generation
    logic rdy = 1'b1;
    logic tog_mode = 1'b0;
    logic tog_bit = 1'b0;

    // monitor state
    logic [31:0] beat_data [0:63];
    logic        beat_last [0:63];
    int          beat_cyc  [0:63];
    int          beat_n = 0;
    int          cyc = 0;
    int          rd_total = 0;
    int          stall_bad = 0;
    int          stall_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always #5 clk = ~clk;

    assign fifo_empty    = (rd_ptr == wr_ptr) || hold_empty;
    assign m_axis_tready = tog_mode ? tog_bit : rdy;

    fifo_axis_packetizer dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .pkt_len       (pkt_len),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .pkt_count     (pkt_count),
        .busy          (busy)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        tog_bit <= ~tog_bit;
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) rd_total <= rd_total + 1;
        if (rst && m_axis_tvalid && m_axis_tready) begin
            beat_data[beat_n[5:0]] <= m_axis_tdata;
            beat_last[beat_n[5:0]] <= m_axis_tlast;
            beat_cyc[beat_n[5:0]]  <= cyc;
            beat_n                 <= beat_n + 1;
        end
        if (rst && prev_stall &&
            !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
            stall_bad <= stall_bad + 1;
        if (rst && m_axis_tvalid && !m_axis_tready) stall_seen <= stall_seen + 1;
        prev_stall <= rst && m_axis_tvalid && !m_axis_tready;
        prev_data  <= m_axis_tdata;
        prev_last  <= m_axis_tlast;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_count(input string tag, input logic [31:0] target, input int budget);
        int n = 0;
        while (pkt_count !== target && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, pkt_count, target);
    endtask

    task automatic start_pulse(input logic [15:0] len);
        pkt_len = len;
        enable  = 1'b1;
        step(1);
        enable  = 1'b0;
    endtask

    initial begin
        int b;
        int c0;
        int busy_seen;
        int rd0;
        int n;
        logic [31:0] exp_first;

        rst = 1'b0; enable = 1'b0; pkt_len = 16'd0;
        step(3);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast",  m_axis_tlast, 1'b0);
        chk("rst_tdata",  m_axis_tdata, 32'd0);
        chk("rst_count",  pkt_count, 32'd0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_rd_en",  fifo_rd_en, 1'b0);
        chk("tkeep",      m_axis_tkeep, 4'hF);
        rst = 1'b1;
        step(1);

        // two back-to-back 4-word packets, ready always high
        for (int i = 1; i <= 8; i++) push(i);
        b = beat_n;
        c0 = cyc;
        pkt_len = 16'd4;
        enable = 1'b1;
        wait_count("p4_count", 32'd2, 100);
        enable = 1'b0;
        step(3);
        chk("p4_beats", beat_n - b, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("p4_beat%0d", i), {beat_last[(b+i)%64], beat_data[(b+i)%64]},
                {(i == 3 || i == 7) ? 1'b1 : 1'b0, 32'(i + 1)});
        chk("p4_first_latency", beat_cyc[b%64] - c0, 3);
        chk("p4_back_to_back",  beat_cyc[(b+3)%64] - beat_cyc[b%64], 3);

        // 8-word packet with ready toggling every cycle
        for (int i = 11; i <= 18; i++) push(i);
        b = beat_n;
        tog_mode = 1'b1;
        start_pulse(16'd8);
        wait_count("p8_count", 32'd3, 200);
        tog_mode = 1'b0;
        step(3);
        chk("p8_beats", beat_n - b, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("p8_beat%0d", i), {beat_last[(b+i)%64], beat_data[(b+i)%64]},
                {(i == 7) ? 1'b1 : 1'b0, 32'(i + 11)});
        chk("p8_stall_stable", stall_bad, 0);
        chk("p8_stalls_seen", stall_seen != 0, 1'b1);

        // 6-word packet with the FIFO going empty after 3 reads
        for (int i = 21; i <= 26; i++) push(i);
        b = beat_n;
        rd0 = rd_total;
        start_pulse(16'd6);
        n = 0;
        while (rd_total < rd0 + 3 && n < 50) begin step(1); n++; end
        hold_empty = 1'b1;
        chk("p6_reads_before_gap", rd_total - rd0, 3);
        step(10);
        chk("p6_gap_tvalid", m_axis_tvalid, 1'b0);
        hold_empty = 1'b0;
        wait_count("p6_count", 32'd4, 100);
        step(3);
        chk("p6_beats", beat_n - b, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("p6_beat%0d", i), {beat_last[(b+i)%64], beat_data[(b+i)%64]},
                {(i == 5) ? 1'b1 : 1'b0, 32'(i + 21)});
        chk("p6_gap_seen", (beat_cyc[(b+3)%64] - beat_cyc[(b+2)%64]) > 5, 1'b1);

        // zero length with enable held: nothing happens even with data waiting
        push(32'd99);
        rd0 = rd_total;
        b = beat_n;
        busy_seen = 0;
        pkt_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (busy) busy_seen++;
        end
        enable = 1'b0;
        chk("len0_reads", rd_total - rd0, 0);
        chk("len0_busy", busy_seen, 0);
        chk("len0_beats", beat_n - b, 0);
        chk("len0_count", pkt_count, 32'd4);

        // reset after two beats of a 5-word packet
        for (int i = 31; i <= 38; i++) push(i);
        b = beat_n;
        start_pulse(16'd5);
        n = 0;
        while (beat_n < b + 2 && n < 50) begin step(1); n++; end
        chk("mid_first_beat", beat_data[b%64], 32'd99);
        rst = 1'b0;
        step(1);
        chk("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_tlast",  m_axis_tlast, 1'b0);
        chk("mid_rst_tdata",  m_axis_tdata, 32'd0);
        chk("mid_rst_count",  pkt_count, 32'd0);
        chk("mid_rst_busy",   busy, 1'b0);
        rst = 1'b1;
        step(1);
        chk("post_rst_rd_en", fifo_rd_en, 1'b0);
        exp_first = mem[rd_ptr[5:0]];
        b = beat_n;
        start_pulse(16'd5);
        pkt_len = 16'd2;
        wait_count("post_rst_count", 32'd1, 100);
        step(3);
        chk("post_rst_beats", beat_n - b, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("post_rst_beat%0d", i), {beat_last[(b+i)%64], beat_data[(b+i)%64]},
                {(i == 4) ? 1'b1 : 1'b0, exp_first + 32'(i)});

        // counter wrap through backdoor preset, single-beat packet
        dut.r_pkt_count = 32'hFFFF_FFFF;
        step(1);
        chk("wrap_preset", pkt_count, 32'hFFFF_FFFF);
        push(32'd41);
        b = beat_n;
        start_pulse(16'd1);
        wait_count("wrap_count", 32'd0, 50);
        step(3);
        chk("len1_beats", beat_n - b, 1);
        chk("len1_beat", {beat_last[b%64], beat_data[b%64]}, {1'b1, 32'd41});
        chk("final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fifo_axis_packetizer.md
FIFO_AXIS_PACKETIZER -- requirements
Module: fifo_axis_packetizer

Interface
REQ-001 Parameter DATA_W, default 32, FIFO and stream data width in bits (multiple of 8).
REQ-002 Parameter LEN_W, default 16, width of the packet-length input.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 enable  input  1  permits new packets to start; sampled only in IDLE.
REQ-006 pkt_len  input  LEN_W  words per packet; latched at packet start.
REQ-007 fifo_empty  input  1  upstream standard FIFO empty flag.
REQ-008 fifo_rd_en  output  1  upstream FIFO read strobe.
REQ-009 fifo_dout  input  DATA_W  upstream FIFO read data, valid one cycle after fifo_rd_en.
REQ-010 m_axis_tdata  output  DATA_W  stream data.
REQ-011 m_axis_tvalid  output  1  stream valid.
REQ-012 m_axis_tready  input  1  downstream ready.
REQ-013 m_axis_tlast  output  1  marks final beat of a packet.
REQ-014 m_axis_tkeep  output  DATA_W/8  byte enables, constant all-ones.
REQ-015 pkt_count  output  32  completed packets since reset.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, FLUSH.
REQ-018 IDLE->STREAM when enable=1 and pkt_len!=0; pkt_len latched, issued-word and sent-word counters cleared the same cycle.
REQ-019 pkt_len=0 with enable=1 SHALL leave the FSM in IDLE; no reads, no beats.
REQ-020 STREAM->FLUSH in the cycle the issued-word count reaches the latched length.
REQ-021 FLUSH->IDLE on the handshake (tvalid&tready) of the tlast beat; enable re-sampled in IDLE next cycle, so minimum one idle cycle between packets.
REQ-022 fifo_rd_en SHALL assert only in STREAM with fifo_empty=0, issued<len, and (buffer occupancy + reads in flight) < 2.
REQ-023 Read data SHALL be captured into a 2-entry output buffer one cycle after fifo_rd_en; no word SHALL be dropped or duplicated under any tready pattern.
REQ-024 Sustained throughput SHALL be one beat per cycle when fifo_empty=0 and tready=1; first beat of a packet appears 2 cycles after the IDLE->STREAM transition.
REQ-025 While tvalid=1 and tready=0, tdata/tlast SHALL hold stable and tvalid SHALL not drop.
REQ-026 tlast SHALL be 1 exactly on the beat whose sent-word index equals len-1; pkt_len=1 gives a single beat with tlast=1.
REQ-027 enable deasserted mid-packet SHALL NOT truncate: the current packet completes with its latched length.
REQ-028 Changes on pkt_len after latching SHALL have no effect on the current packet.
REQ-029 pkt_count SHALL increment by 1 on each tlast handshake and wrap 0xFFFFFFFF->0.
REQ-030 fifo_empty asserting mid-packet SHALL stall reads with tvalid low once the buffer drains; streaming resumes without loss.

Reset
REQ-031 In reset: state=IDLE, fifo_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_count=0, busy=0, buffer emptied, counters 0.
REQ-032 Reset mid-packet SHALL abort the packet immediately; a read in flight at reset SHALL be discarded; first beat after reset starts a new packet.

Structure
REQ-033 Shared package SHALL hold DATA_W/LEN_W defaults and the FSM state encoding.
REQ-034 The 2-entry output buffer SHALL be a sub-module axis_skid_buf (DATA_W+1 bits wide: data + last).

Verification
REQ-035 pkt_len=4, FIFO preloaded with 1..8, tready=1: two packets, beats 1,2,3,4(tlast) and 5,6,7,8(tlast), pkt_count=2.
REQ-036 pkt_len=8, tready toggling 1/0 each cycle: beats 1..8 in order, tdata stable across stalls, tlast only on 8.
REQ-037 pkt_len=6, fifo_empty forced high after 3 words for 10 cycles: beats 1..6 with a gap, no loss, tlast on 6.
REQ-038 pkt_len=0, enable=1 for 20 cycles: fifo_rd_en never asserts, busy=0, pkt_count=0.
REQ-039 rst=0 for one cycle after 2 beats of a pkt_len=5 packet: outputs return to reset values; next packet starts at the next FIFO word with a fresh count.
REQ-040 pkt_count forced near wrap (0xFFFFFFFF via 2^32-1 packets or backdoor): next tlast handshake gives 0.
